// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// FSM state encoding, signedness mode encoding and the counter-width helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_negate.sv
// Conditional two's-complement: out = en ? -in : in.
// Used for operand magnitudes and for the final product sign fix-up.
module seq_mult_negate #(
    parameter int N = 32
) (
    input  logic         en,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);

    assign out = en ? (~in + N'(1)) : in;

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, hi/lo result with busy/done.
// Build option: define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_mag_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_mag_b;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_done;

    logic                 w_sign_a;
    logic                 w_sign_b;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_sign_a = (is_signed == MODE_SIGNED) & src_a[WIDTH-1];
    assign w_sign_b = (is_signed == MODE_SIGNED) & src_b[WIDTH-1];

    seq_mult_negate #(.N(WIDTH)) u_neg_a (.en(w_sign_a), .in(src_a), .out(w_mag_a));
    seq_mult_negate #(.N(WIDTH)) u_neg_b (.en(w_sign_b), .in(src_b), .out(w_mag_b));
    seq_mult_negate #(.N(2*WIDTH)) u_neg_p (.en(r_neg), .in(r_acc), .out(w_prod));

    // Start is honoured in FINISH too, giving back-to-back operations.
    assign w_accept = start & ((r_state == IDLE) | (r_state == FINISH));

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign w_last = (r_cnt == CNT_W'(1)) | (r_mag_b[WIDTH-1:1] == '0);
`else
    assign w_last = (r_cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            IDLE:    if (start) w_state_nxt = BUSY;
            BUSY: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = FINISH;
            end
            FINISH:  w_state_nxt = start ? BUSY : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_prod  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mag_a <= {{WIDTH{1'b0}}, w_mag_a};
                r_mag_b <= w_mag_b;
                r_acc   <= '0;
                r_cnt   <= CNT_W'(WIDTH);
                r_neg   <= w_sign_a ^ w_sign_b;
            end else if (r_state == BUSY) begin
                if (r_mag_b[0]) r_acc <= r_acc + r_mag_a;
                r_mag_a <= r_mag_a << 1;
                r_mag_b <= r_mag_b >> 1;
                r_cnt   <= r_cnt - CNT_W'(1);
            end
            // The result is published only here, so hi/lo never show partial sums.
            if (r_state == FINISH) begin
                r_prod <= w_prod;
                r_done <= 1'b1;
            end
        end
    end

    assign done = r_done;
    assign hi   = r_prod[2*WIDTH-1:WIDTH];
    assign lo   = r_prod[WIDTH-1:0];

endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
Parametrised iterative shift-add multiplier for the datapath hi/lo result registers. It takes two WIDTH-bit operands on a start pulse and iterates one multiplier bit per cycle. It returns a 2*WIDTH-bit product on hi/lo with a busy/done handshake. It supports signed and unsigned modes selected per operation, and replaces the fixed 32-bit signed-only multiplier in the execute stage.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH; legal range 4..64.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only while busy=0.
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
src_a  input  WIDTH  multiplicand; captured with start.
src_b  input  WIDTH  multiplier; captured with start.
busy  output  1  high while iterating.
done  output  1  single-cycle pulse when hi/lo are updated.
hi  output  WIDTH  product bits [2W-1:W].
lo  output  WIDTH  product bits [W-1:0].

Behaviour:
- Reset (async, reset=0): state IDLE; busy=0, done=0, hi=0, lo=0; internal operand, accumulator and counter registers cleared. Reset mid-operation aborts the operation and leaves no partial result on hi/lo.
- States:
  - IDLE: start=1 -> BUSY.
  - BUSY: counter reaches 0 -> FINISH.
  - FINISH: lasts 1 cycle. start=1 -> BUSY; otherwise -> IDLE.
- Capture on accepting edge:
  - sign_a = is_signed & src_a[W-1]; sign_b likewise.
  - mag_a = sign_a ? -src_a : src_a, zero-extended to 2W.
  - mag_b = sign_b ? -src_b : src_b, W bits unsigned.
  - neg = sign_a ^ sign_b; acc = 0; counter = WIDTH.
- BUSY iteration, per cycle:
  - if mag_b[0], acc += mag_a (2W-bit, no overflow possible);
  - mag_a <<= 1; mag_b >>= 1; counter -= 1.
- FINISH: {hi,lo} <= neg ? -acc : acc (2W-bit two's complement); done=1 for this cycle only; busy=0.
- Latency: start sampled at edge 0; busy=1 after edges 1..WIDTH; done=1 and hi/lo valid after edge WIDTH+1.
- hi/lo hold their value until the next FINISH; they are never updated during BUSY.
- start while busy=1 is ignored; no queueing.
- start during FINISH is accepted and gives back-to-back operation with no IDLE gap.
- Signed minimum value -2^(W-1): its magnitude 2^(W-1) fits in W unsigned bits; the product is exact.
- Operands that change after capture have no effect on the current operation.

Optional Feature:
SEQ_MULT_EARLY_EXIT_EN:
- Defined: in BUSY, if the shifted mag_b equals 0 after the current iteration, go to FINISH on the next edge regardless of counter. BUSY always lasts at least 1 cycle. Latency = max(1, msb_index(mag_b)+1) + 1 cycles.
- Undefined: latency is fixed at WIDTH+1 cycles for all operands.
- Results are identical in both builds.

Decomposition:
- Package seq_mult_pkg holds:
  - state typedef (IDLE, BUSY, FINISH) as a 2-bit enum;
  - mode encoding constants MODE_UNSIGNED=0, MODE_SIGNED=1;
  - function for CNT_W derivation.
- One sub-module, seq_mult_negate: parametrised conditional two's-complement (en, in[N], out[N]). It is instantiated for operand magnitude (N=WIDTH, twice) and product fix-up (N=2*WIDTH).

Test Plan:
- WIDTH=32, unsigned, 7 x 6 -> done at edge 33, hi=0x00000000, lo=0x0000002A; busy high exactly 32 cycles.
- Signed, -3 (0xFFFFFFFD) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed, 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000; unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- start pulsed with new operands at edge 10 of a busy operation -> ignored; the original result is delivered. A second start held high during FINISH -> back-to-back; the second done arrives 33 cycles after the first.
- reset=0 at edge 15 mid-operation -> busy=0, done=0, hi=lo=0 immediately; no done pulse follows after release.
- With SEQ_MULT_EARLY_EXIT_EN: unsigned 9 x 3 -> done at edge 3, lo=27. 5 x 0 -> done at edge 2, lo=0. The same operands without the macro -> done at edge 33.
